// File: rtl/mem_port_bridge.sv
// Multi-channel bridge between core request/response streams and valid/ready memory ports,
// with per-channel credits and in-order response buffering. Define MEM_PORT_BRIDGE_RESP_BYPASS_EN for 0-cycle responses.
module mem_port_bridge #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          core_req_valid,
  output logic [NUM_CH-1:0]          core_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   core_req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   core_req_data,
  input  logic [NUM_CH-1:0]          core_req_fcn,
  input  logic [NUM_CH*3-1:0]        core_req_typ,
  output logic [NUM_CH-1:0]          mem_req_valid,
  input  logic [NUM_CH-1:0]          mem_req_ready,
  output logic [NUM_CH*ADDR_W-1:0]   mem_req_addr,
  output logic [NUM_CH*DATA_W-1:0]   mem_req_data,
  output logic [NUM_CH-1:0]          mem_req_fcn,
  output logic [NUM_CH*3-1:0]        mem_req_typ,
  input  logic [NUM_CH-1:0]          mem_resp_valid,
  input  logic [NUM_CH*DATA_W-1:0]   mem_resp_data,
  output logic [NUM_CH-1:0]          core_resp_valid,
  input  logic [NUM_CH-1:0]          core_resp_ready,
  output logic [NUM_CH*DATA_W-1:0]   core_resp_data,
  output logic [NUM_CH*ADDR_W-1:0]   core_resp_addr,
  output logic [NUM_CH-1:0]          err_spurious
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  assign mem_req_addr = core_req_addr;
  assign mem_req_data = core_req_data;
  assign mem_req_fcn  = core_req_fcn;
  assign mem_req_typ  = core_req_typ;

  // Handshakes: a transfer happens on a cycle where valid & ready are both high; valid never
  // waits on ready, and a source holds its payload until the transfer. mem_resp_valid is a
  // pulse that cannot be stalled, which is why credits are only returned on core consumption.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CW-1:0]     outs;   // address FIFO occupancy == requests in flight or buffered
    logic [CW-1:0]     r_cnt;  // response FIFO occupancy
    logic [PW-1:0]     a_wr, a_rd, r_wr, r_rd;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              credit_ok, req_fire, pending, resp_hit;
    logic              bypass, resp_fire, push, pop_r, err_q;

    assign credit_ok         = (outs < CW'(DEPTH));
    assign mem_req_valid[i]  = core_req_valid[i] & credit_ok;
    assign core_req_ready[i] = mem_req_ready[i] & credit_ok;
    assign req_fire          = core_req_valid[i] & core_req_ready[i];

    assign pending  = (outs != r_cnt);
    assign resp_hit = mem_resp_valid[i] & pending;

`ifdef MEM_PORT_BRIDGE_RESP_BYPASS_EN
    assign bypass = resp_hit & (r_cnt == '0);
`else
    assign bypass = 1'b0;
`endif

    assign core_resp_valid[i] = (r_cnt != '0) | bypass;
    assign core_resp_data[i*DATA_W +: DATA_W] =
      bypass ? mem_resp_data[i*DATA_W +: DATA_W] : data_mem[r_rd];
    assign core_resp_addr[i*ADDR_W +: ADDR_W] = addr_mem[a_rd];
    assign err_spurious[i]    = err_q;

    // A bypassed response that is consumed immediately never touches the response FIFO.
    assign resp_fire = core_resp_valid[i] & core_resp_ready[i];
    assign push      = resp_hit & ~(bypass & core_resp_ready[i]);
    assign pop_r     = resp_fire & ~bypass;

    always_ff @(posedge clock) begin
      if (reset) begin
        outs  <= '0;
        r_cnt <= '0;
        a_wr  <= '0;
        a_rd  <= '0;
        r_wr  <= '0;
        r_rd  <= '0;
        err_q <= 1'b0;
      end else begin
        if (req_fire)  a_wr <= a_wr + PW'(1);
        if (resp_fire) a_rd <= a_rd + PW'(1);
        if (push)      r_wr <= r_wr + PW'(1);
        if (pop_r)     r_rd <= r_rd + PW'(1);

        if (req_fire && !resp_fire)      outs <= outs + CW'(1);
        else if (!req_fire && resp_fire) outs <= outs - CW'(1);

        if (push && !pop_r)      r_cnt <= r_cnt + CW'(1);
        else if (!push && pop_r) r_cnt <= r_cnt - CW'(1);

        if (mem_resp_valid[i] && !pending) err_q <= 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (req_fire) addr_mem[a_wr] <= core_req_addr[i*ADDR_W +: ADDR_W];
      if (push)     data_mem[r_wr] <= mem_resp_data[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_mem_port_bridge.sv
// Scoreboarded bench for mem_port_bridge: directed requests push expected {addr,data},
// a negedge monitor pops and compares on every core response transfer.
module tb_mem_port_bridge;
  localparam int NUM_CH = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef MEM_PORT_BRIDGE_RESP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NUM_CH-1:0]        core_req_valid, core_req_ready, core_req_fcn;
  logic [NUM_CH*ADDR_W-1:0] core_req_addr;
  logic [NUM_CH*DATA_W-1:0] core_req_data;
  logic [NUM_CH*3-1:0]      core_req_typ;
  logic [NUM_CH-1:0]        mem_req_valid, mem_req_ready, mem_req_fcn;
  logic [NUM_CH*ADDR_W-1:0] mem_req_addr;
  logic [NUM_CH*DATA_W-1:0] mem_req_data;
  logic [NUM_CH*3-1:0]      mem_req_typ;
  logic [NUM_CH-1:0]        mem_resp_valid;
  logic [NUM_CH*DATA_W-1:0] mem_resp_data;
  logic [NUM_CH-1:0]        core_resp_valid, core_resp_ready, err_spurious;
  logic [NUM_CH*DATA_W-1:0] core_resp_data;
  logic [NUM_CH*ADDR_W-1:0] core_resp_addr;

  mem_port_bridge #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_addr(core_req_addr), .core_req_data(core_req_data),
    .core_req_fcn(core_req_fcn), .core_req_typ(core_req_typ),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .core_resp_valid(core_resp_valid), .core_resp_ready(core_resp_ready),
    .core_resp_data(core_resp_data), .core_resp_addr(core_resp_addr),
    .err_spurious(err_spurious)
  );

  int checks = 0;
  int failures = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] mon_e;

  // memory model for ch0 plus manual pulse drivers
  int   cyc = 0;
  bit   mem_auto = 1'b0;
  int   mem_lat = 1;
  int   pend_due_q[$];
  logic [DATA_W-1:0] pend_data_q[$];
  logic model_v = 1'b0;
  logic [DATA_W-1:0] model_d = '0;
  logic [NUM_CH-1:0] man_v;
  logic [NUM_CH*DATA_W-1:0] man_d;
  bit   rand_ready = 1'b0;
  logic rnd_rdy = 1'b0;
  logic [NUM_CH-1:0] resp_rdy_drv;

  assign mem_resp_valid  = man_v | {{(NUM_CH-1){1'b0}}, model_v};
  assign mem_resp_data   = {man_d[NUM_CH*DATA_W-1:DATA_W], model_v ? model_d : man_d[DATA_W-1:0]};
  assign core_resp_ready = {resp_rdy_drv[NUM_CH-1:1], rand_ready ? rnd_rdy : resp_rdy_drv[0]};

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc = cyc + 1;
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
    if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
      model_v = 1'b1;
      model_d = pend_data_q.pop_front();
      void'(pend_due_q.pop_front());
    end else begin
      model_v = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (mem_auto && !reset && mem_req_valid[0] && mem_req_ready[0]) begin
      pend_due_q.push_back(cyc + mem_lat);
      pend_data_q.push_back(mem_word(core_req_addr[ADDR_W-1:0]));
    end
  end

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (core_resp_valid[0] && core_resp_ready[0]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp0_unexpected actual addr=0x%0h required=no response", core_resp_addr[ADDR_W-1:0]);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp0_addr", 64'(core_resp_addr[ADDR_W-1:0]), 64'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
          check("resp0_data", 64'(core_resp_data[DATA_W-1:0]), 64'(mon_e[DATA_W-1:0]));
        end
      end
      if (core_resp_valid[1]) check("resp1_valid", 64'(core_resp_valid[1]), 64'd0);
    end
  end

  // driver tasks
  task automatic send_req(input logic [ADDR_W-1:0] addr);
    int n;
    @(posedge clock); #1;
    core_req_valid[0] = 1'b1;
    core_req_addr[ADDR_W-1:0] = addr;
    core_req_data[DATA_W-1:0] = ~addr;
    core_req_fcn[0] = addr[2];
    n = 0;
    while (n < 200) begin
      @(negedge clock);
      if (core_req_ready[0]) break;
      n++;
    end
    if (core_req_ready[0]) exp_q.push_back({addr, mem_word(addr)});
    else check("send_req_ready", 64'(core_req_ready[0]), 64'd1);
  endtask

  task automatic req_idle();
    @(posedge clock); #1;
    core_req_valid[0] = 1'b0;
  endtask

  task automatic mem_pulse(input int ch, input logic [DATA_W-1:0] d);
    @(posedge clock); #1;
    man_v[ch] = 1'b1;
    man_d[ch*DATA_W +: DATA_W] = d;
    @(posedge clock); #1;
    man_v[ch] = 1'b0;
  endtask

  task automatic drain();
    int n;
    @(posedge clock); #1;
    resp_rdy_drv[0] = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || core_resp_valid[0]) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clock); #1;
    resp_rdy_drv[0] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    core_req_valid = '0;
    core_req_addr = '0;
    core_req_data = '0;
    core_req_fcn = '0;
    core_req_typ = {3'b000, 3'b010};
    mem_req_ready = 2'b11;
    man_v = '0;
    man_d = '0;
    resp_rdy_drv = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // reset state
    @(negedge clock);
    check("rst_core_resp_valid", 64'(core_resp_valid), 64'd0);
    check("rst_err_spurious", 64'(err_spurious), 64'd0);
    check("rst_core_req_ready", 64'(core_req_ready), 64'b11);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);

    @(posedge clock); #1;
    mem_req_ready = 2'b01;
    core_req_valid[1] = 1'b1;
    @(negedge clock);
    check("ready_follows_mem", 64'(core_req_ready), 64'b01);
    check("valid_without_ready", 64'(mem_req_valid), 64'b10);
    @(posedge clock); #1;
    core_req_valid[1] = 1'b0;
    mem_req_ready = 2'b11;

    // single load ch0
    mem_auto = 1'b0;
    send_req(32'h100);
    check("load_mem_req_valid", 64'(mem_req_valid[0]), 64'd1);
    check("load_mem_req_addr", 64'(mem_req_addr[ADDR_W-1:0]), 64'h100);
    check("load_mem_req_typ", 64'(mem_req_typ[2:0]), 64'b010);
    check("load_mem_req_fcn", 64'(mem_req_fcn[0]), 64'd0);
    req_idle();
    @(posedge clock); #1;
    man_v[0] = 1'b1;
    man_d[DATA_W-1:0] = 32'hDEADBEEF;
    @(negedge clock);
    check("load_valid_at_pulse", 64'(core_resp_valid[0]), 64'(BYP));
    @(posedge clock); #1;
    man_v[0] = 1'b0;
    @(negedge clock);
    check("load_valid_next", 64'(core_resp_valid[0]), 64'd1);
    check("load_data", 64'(core_resp_data[DATA_W-1:0]), 64'hDEADBEEF);
    check("load_addr", 64'(core_resp_addr[ADDR_W-1:0]), 64'h100);
    @(posedge clock); #1;
    resp_rdy_drv[0] = 1'b1;
    @(posedge clock); #1;
    resp_rdy_drv[0] = 1'b0;
    @(negedge clock);
    check("load_drained", 64'(core_resp_valid[0]), 64'd0);
    check("load_credit_back", 64'(core_req_ready[0]), 64'd1);

    // credit exhaustion
    mem_auto = 1'b1;
    mem_lat = 1;
    send_req(32'h0);
    send_req(32'h4);
    send_req(32'h8);
    send_req(32'hC);
    @(posedge clock); #1;
    core_req_addr[ADDR_W-1:0] = 32'h10;
    core_req_data[DATA_W-1:0] = ~32'h10;
    @(negedge clock);
    check("full_core_req_ready", 64'(core_req_ready[0]), 64'd0);
    check("full_mem_req_valid", 64'(mem_req_valid[0]), 64'd0);
    repeat (3) @(negedge clock);
    check("full_still_blocked", 64'(core_req_ready[0]), 64'd0);
    check("full_resp_buffered", 64'(core_resp_valid[0]), 64'd1);
    @(posedge clock); #1;
    resp_rdy_drv[0] = 1'b1;
    @(negedge clock);
    check("full_pop_cycle", 64'(core_req_ready[0]), 64'd0);
    @(posedge clock); #1;
    resp_rdy_drv[0] = 1'b0;
    @(negedge clock);
    check("credit_reopen_ready", 64'(core_req_ready[0]), 64'd1);
    check("credit_reopen_valid", 64'(mem_req_valid[0]), 64'd1);
    exp_q.push_back({32'h10, mem_word(32'h10)});
    req_idle();
    drain();

    // ordering and pointer wrap with random core ready
    @(posedge clock); #1;
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) send_req(32'(i * 4));
    req_idle();
    repeat (4) @(posedge clock);
    #1;
    rand_ready = 1'b0;
    drain();

    // simultaneous request fire and response fire
    mem_auto = 1'b0;
    send_req(32'h200);
    send_req(32'h204);
    req_idle();
    mem_pulse(0, mem_word(32'h200));
    @(negedge clock);
    check("sim_buffered", 64'(core_resp_valid[0]), 64'd1);
    @(posedge clock); #1;
    core_req_valid[0] = 1'b1;
    core_req_addr[ADDR_W-1:0] = 32'h208;
    resp_rdy_drv[0] = 1'b1;
    @(negedge clock);
    check("sim_req_ready", 64'(core_req_ready[0]), 64'd1);
    check("sim_resp_valid", 64'(core_resp_valid[0]), 64'd1);
    exp_q.push_back({32'h208, mem_word(32'h208)});
    @(posedge clock); #1;
    core_req_valid[0] = 1'b0;
    resp_rdy_drv[0] = 1'b0;
    @(negedge clock);
    check("sim_fifo_empty", 64'(core_resp_valid[0]), 64'd0);
    send_req(32'h20C);
    send_req(32'h210);
    @(posedge clock); #1;
    core_req_addr[ADDR_W-1:0] = 32'h214;
    @(negedge clock);
    check("sim_outs_full", 64'(core_req_ready[0]), 64'd0);
    req_idle();
    @(posedge clock); #1;
    resp_rdy_drv[0] = 1'b1;
    mem_pulse(0, mem_word(32'h204));
    mem_pulse(0, mem_word(32'h208));
    mem_pulse(0, mem_word(32'h20C));
    mem_pulse(0, mem_word(32'h210));
    drain();

    // spurious response on ch1, ch0 unaffected
    mem_pulse(1, 32'h12345678);
    @(negedge clock);
    check("spur_err", 64'(err_spurious), 64'b10);
    check("spur_no_resp1", 64'(core_resp_valid[1]), 64'd0);
    mem_auto = 1'b1;
    send_req(32'h300);
    send_req(32'h304);
    req_idle();
    drain();
    check("spur_ch0_clean", 64'(err_spurious), 64'b10);
    do_reset();
    @(negedge clock);
    check("spur_reset_clears", 64'(err_spurious), 64'd0);
    check("spur_reset_resp_valid", 64'(core_resp_valid), 64'd0);
    check("spur_reset_req_ready", 64'(core_req_ready), 64'b11);

    // reset mid-operation discards the outstanding request
    mem_auto = 1'b0;
    send_req(32'h500);
    req_idle();
    do_reset();
    exp_q.delete();
    mem_pulse(0, mem_word(32'h500));
    @(negedge clock);
    check("midreset_err", 64'(err_spurious), 64'b01);
    check("midreset_no_resp", 64'(core_resp_valid), 64'd0);
    do_reset();

`ifdef MEM_PORT_BRIDGE_RESP_BYPASS_EN
    // same-cycle bypass with empty FIFO and ready core
    send_req(32'h400);
    req_idle();
    @(posedge clock); #1;
    resp_rdy_drv[0] = 1'b1;
    man_v[0] = 1'b1;
    man_d[DATA_W-1:0] = mem_word(32'h400);
    @(negedge clock);
    check("byp_valid", 64'(core_resp_valid[0]), 64'd1);
    check("byp_data", 64'(core_resp_data[DATA_W-1:0]), 64'(mem_word(32'h400)));
    check("byp_addr", 64'(core_resp_addr[ADDR_W-1:0]), 64'h400);
    @(posedge clock); #1;
    man_v[0] = 1'b0;
    resp_rdy_drv[0] = 1'b0;
    @(negedge clock);
    check("byp_no_occupancy", 64'(core_resp_valid[0]), 64'd0);
    check("byp_credit_back", 64'(core_req_ready[0]), 64'd1);
`endif

    repeat (2) @(posedge clock);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_bridge.md
Name: mem_port_bridge

Overview:
- Parametrised multi-channel adapter between the core's memory request/response streams and simple valid/ready memory ports (imem, dmem, extra ports).
- Replaces the combinational per-port wiring. Tracks outstanding requests with credits and buffers responses in order.
- Returns each response tagged with the address of the request that produced it, independent of memory latency.

Parameters:
- NUM_CH, 2, number of independent memory channels (ch0 = imem, ch1 = dmem).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- DEPTH, 4, maximum outstanding requests per channel; also the depth of the response/address FIFOs (power of two, ≥2).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- core_req_valid  in  NUM_CH  per-channel request valid from core
- core_req_ready  out  NUM_CH  per-channel request accept
- core_req_addr  in  NUM_CH*ADDR_W  request address, ch i at [i*ADDR_W +: ADDR_W]
- core_req_data  in  NUM_CH*DATA_W  store data
- core_req_fcn  in  NUM_CH  0 = load, 1 = store
- core_req_typ  in  NUM_CH*3  access size code, passed through
- mem_req_valid  out  NUM_CH  request valid to memory
- mem_req_ready  in  NUM_CH  memory accepts request
- mem_req_addr / mem_req_data / mem_req_fcn / mem_req_typ  out  as core side  combinational passthrough of core fields
- mem_resp_valid  in  NUM_CH  one-cycle response pulse; memory cannot be back-pressured
- mem_resp_data  in  NUM_CH*DATA_W  response data
- core_resp_valid  out  NUM_CH  buffered response available
- core_resp_ready  in  NUM_CH  core consumes response
- core_resp_data  out  NUM_CH*DATA_W  response data
- core_resp_addr  out  NUM_CH*ADDR_W  address of the originating request
- err_spurious  out  NUM_CH  sticky: response received with no request outstanding

Behaviour:
- Channels are fully independent. All rules below apply per channel.
- Credits: counter outs, width $clog2(DEPTH+1), range 0..DEPTH. credit_ok = (outs < DEPTH).
- Request path:
  - mem_req_valid = core_req_valid & credit_ok
  - core_req_ready = mem_req_ready & credit_ok
  - Payload fields pass through combinationally.
  - Request fire = core_req_valid & core_req_ready.
  - No dependency of valid on ready.
- Address FIFO (DEPTH entries): on request fire, push core_req_addr.
- Response FIFO (DEPTH entries): on mem_resp_valid with outstanding_issued > 0, push mem_resp_data.
  - outstanding_issued = entries in address FIFO minus entries in response FIFO.
- Every accepted request (load or store) produces exactly one mem_resp_valid pulse, in issue order.
- Core response:
  - core_resp_valid = response FIFO non-empty.
  - core_resp_data = response FIFO head.
  - core_resp_addr = address FIFO head.
  - Response fire = core_resp_valid & core_resp_ready pops both FIFOs together.
- Latency: mem_resp_valid at cycle t gives core_resp_valid at t+1 (registered), unless the optional feature is enabled.
- outs counter:
  - +1 on request fire.
  - −1 on response fire.
  - Both in the same cycle: unchanged.
- Credits are released only when the core consumes the response, so the response FIFO can never overflow.
- Full: outs == DEPTH gives mem_req_valid = 0 and core_req_ready = 0. Credits re-open the cycle after a response fire.
- Simultaneous mem_resp_valid push and core response pop on a non-empty FIFO: both occur and occupancy is unchanged.
- Spurious response: mem_resp_valid while outstanding_issued == 0. Data is dropped, err_spurious is set, and only reset clears it.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are distinguished by the outs counter and occupancy counters, not by pointer equality.
- Reset:
  - Clears pointers, counters and err_spurious.
  - Outputs after reset: core_req_ready = mem_req_ready (credits available), mem_req_valid = core_req_valid, core_resp_valid = 0, err_spurious = 0.
  - Reset mid-operation discards all in-flight bookkeeping. Responses arriving afterwards flag err_spurious.

Optional Feature:
- MEM_PORT_BRIDGE_RESP_BYPASS_EN
  - Defined: when the response FIFO is empty and mem_resp_valid is high with an outstanding request, the response appears on core_resp_* in the same cycle (core_resp_data = mem_resp_data, core_resp_addr = address FIFO head).
  - If core_resp_ready is also high, the response fires with no FIFO push. Otherwise it is pushed as normal.
  - Latency becomes 0 cycles.
  - Not defined: strictly registered responses with 1-cycle latency.

Test Plan:
- Single load, ch0: req addr 0x100 accepted, memory responds 2 cycles later with 0xDEADBEEF -> core_resp_valid 1 cycle after the response, data 0xDEADBEEF, addr 0x100, outs back to 0.
- Credit exhaustion, DEPTH=4: issue 4 requests (addr 0x0, 0x4, 0x8, 0xC) with core_resp_ready=0 -> 5th request sees core_req_ready=0 and mem_req_valid=0. Popping one response re-enables ready the next cycle.
- Ordering and wrap: 10 back-to-back requests with 1-cycle memory latency and random core_resp_ready -> responses delivered in order with matching addrs 0x0..0x24. No drops, pointers wrap twice.
- Simultaneous events: with outs=2 and one buffered response, request fire and response fire in the same cycle -> outs stays 2, FIFO occupancy correct.
- Channel independence and spurious response: ch1 mem_resp_valid with nothing outstanding -> err_spurious[1]=1, ch1 core_resp_valid stays 0, ch0 traffic unaffected. Reset clears the flag.
- Bypass: with MEM_PORT_BRIDGE_RESP_BYPASS_EN defined, FIFO empty and core_resp_ready=1 -> response data and addr visible in the same cycle as mem_resp_valid, with no FIFO occupancy.
